// File: rtl/cpu_pkg.sv
// Shared definitions for the decode/execute pipeline slice.
//   DEF_DATA_W / DEF_REG_ADDR_W / DEF_CTRL_W : default widths
//   CTRL_* : bit positions inside the decoded control bundle
//   CTRL_NOP : control bundle carried by a bubble
package cpu_pkg;

   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_CTRL_W     = 8;

   localparam int CTRL_REG_WRITE = 0;
   localparam int CTRL_MEM_READ  = 1;
   localparam int CTRL_MEM_WRITE = 2;
   localparam int CTRL_MEM_TO_REG = 3;
   localparam int CTRL_ALU_SRC   = 4;
   localparam int CTRL_REG_DST   = 5;
   localparam int CTRL_ALU_OP_LO = 6;
   localparam int CTRL_ALU_OP_HI = 7;

   localparam logic [DEF_CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational RAW hazard detector for the ID stage.
// Ports:
//   ex_valid, ex_reg_write, ex_mem_read, ex_dst : producer currently in EX
//   mem_reg_write, mem_dst                      : producer currently in MEM
//   id_rs, id_rt                                : consumer register numbers in ID
//   hazard                                      : ID instruction must wait
// Build option FORWARDING_EN: when defined only load-use stalls (everything
// else is forwarded); otherwise any RAW against EX or MEM stalls.
module hazard_detect_unit
   import cpu_pkg::*;
#(
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic                  ex_valid,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_dst,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_dst,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   output logic                  hazard
);

   logic ex_match;
   logic mem_match;

   // Register 0 is hardwired, so it never creates a dependency.
   assign ex_match  = ex_valid && (ex_dst != '0) &&
                      ((ex_dst == id_rs) || (ex_dst == id_rt));
   assign mem_match = mem_reg_write && (mem_dst != '0) &&
                      ((mem_dst == id_rs) || (mem_dst == id_rt));

`ifdef FORWARDING_EN
   assign hazard = ex_match && ex_mem_read;

   logic unused_nofwd;
   assign unused_nofwd = ex_reg_write ^ mem_match;
`else
   // WB is not checked: the register file writes on negedge, so decode
   // already sees the WB value in the same cycle.
   assign hazard = (ex_match && ex_reg_write) || mem_match;

   logic unused_fwd;
   assign unused_fwd = ex_mem_read;
`endif

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// Decode -> execute pipeline register with RAW/load-use stall, branch flush
// and downstream back-pressure.
// Ports:
//   clk, reset (async, active-low)
//   id_*            : instruction in decode (valid, operands, regs, imm, ctrl)
//   flush           : branch taken in EX, turn the ID instruction into a bubble
//   stall_ext       : downstream busy, hold EX contents
//   mem_*, wb_*     : later-stage producers (hazard check / forwarding)
//   ex_*            : registered EX-stage view (ex_opA/ex_opB possibly forwarded)
//   id_stall        : combinational, hold PC and IF/ID this cycle
// Build option FORWARDING_EN: enables MEM/WB operand forwarding onto
// ex_opA/ex_opB and relaxes the stall rule to load-use only.
module id_ex_pipeline_reg
   import cpu_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int CTRL_W     = DEF_CTRL_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [DATA_W-1:0]     id_Read_Data_1,
   input  logic [DATA_W-1:0]     id_Read_Data_2,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic                  flush,
   input  logic                  stall_ext,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_dst,
   input  logic [DATA_W-1:0]     mem_result,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_dst,
   input  logic [DATA_W-1:0]     wb_result,
   output logic                  ex_valid,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_dst,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [DATA_W-1:0]     ex_opA,
   output logic [DATA_W-1:0]     ex_opB,
   output logic                  id_stall
);

   logic                  ex_valid_q, ex_valid_d;
   logic [CTRL_W-1:0]     ex_ctrl_q,  ex_ctrl_d;
   logic [REG_ADDR_W-1:0] ex_rs_q,    ex_rs_d;
   logic [REG_ADDR_W-1:0] ex_rt_q,    ex_rt_d;
   logic [REG_ADDR_W-1:0] ex_dst_q,   ex_dst_d;
   logic [DATA_W-1:0]     ex_imm_q,   ex_imm_d;
   logic [DATA_W-1:0]     ex_opa_q,   ex_opa_d;
   logic [DATA_W-1:0]     ex_opb_q,   ex_opb_d;
   logic                  hazard;

   hazard_detect_unit #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_hazard (
      .ex_valid      (ex_valid_q),
      .ex_reg_write  (ex_ctrl_q[CTRL_REG_WRITE]),
      .ex_mem_read   (ex_ctrl_q[CTRL_MEM_READ]),
      .ex_dst        (ex_dst_q),
      .mem_reg_write (mem_reg_write),
      .mem_dst       (mem_dst),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .hazard        (hazard)
   );

   // A flush discards the ID instruction, so there is nothing left to hold.
   assign id_stall = reset && !flush && id_valid && (hazard || stall_ext);

   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_ctrl_d  = ex_ctrl_q;
      ex_rs_d    = ex_rs_q;
      ex_rt_d    = ex_rt_q;
      ex_dst_d   = ex_dst_q;
      ex_imm_d   = ex_imm_q;
      ex_opa_d   = ex_opa_q;
      ex_opb_d   = ex_opb_q;
      if (!stall_ext) begin
         if (flush || (id_valid && hazard)) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_W'(CTRL_NOP);
            ex_rs_d    = '0;
            ex_rt_d    = '0;
            ex_dst_d   = '0;
            ex_imm_d   = '0;
            ex_opa_d   = '0;
            ex_opb_d   = '0;
         end else begin
            ex_valid_d = id_valid;
            ex_ctrl_d  = id_ctrl;
            ex_rs_d    = id_rs;
            ex_rt_d    = id_rt;
            ex_dst_d   = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
            ex_imm_d   = id_imm;
            ex_opa_d   = id_Read_Data_1;
            ex_opb_d   = id_Read_Data_2;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_valid_q <= 1'b0;
         ex_ctrl_q  <= '0;
         ex_rs_q    <= '0;
         ex_rt_q    <= '0;
         ex_dst_q   <= '0;
         ex_imm_q   <= '0;
         ex_opa_q   <= '0;
         ex_opb_q   <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_ctrl_q  <= ex_ctrl_d;
         ex_rs_q    <= ex_rs_d;
         ex_rt_q    <= ex_rt_d;
         ex_dst_q   <= ex_dst_d;
         ex_imm_q   <= ex_imm_d;
         ex_opa_q   <= ex_opa_d;
         ex_opb_q   <= ex_opb_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_ctrl  = ex_ctrl_q;
   assign ex_rs    = ex_rs_q;
   assign ex_rt    = ex_rt_q;
   assign ex_dst   = ex_dst_q;
   assign ex_imm   = ex_imm_q;

`ifdef FORWARDING_EN
   // MEM holds the younger value, so it wins over WB.
   always_comb begin
      ex_opA = ex_opa_q;
      if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rs_q))
         ex_opA = mem_result;
      else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rs_q))
         ex_opA = wb_result;
   end

   always_comb begin
      ex_opB = ex_opb_q;
      if (mem_reg_write && (mem_dst != '0) && (mem_dst == ex_rt_q))
         ex_opB = mem_result;
      else if (wb_reg_write && (wb_dst != '0) && (wb_dst == ex_rt_q))
         ex_opB = wb_result;
   end
`else
   assign ex_opA = ex_opa_q;
   assign ex_opB = ex_opb_q;

   logic unused_fwd;
   assign unused_fwd = ^{mem_result, wb_reg_write, wb_dst, wb_result};
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
module tb_id_ex_pipeline_reg;

   typedef struct packed {
      logic        valid;
      logic [7:0]  ctrl;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic [31:0] imm;
      logic [31:0] a;
      logic [31:0] b;
   } ex_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_Read_Data_1, id_Read_Data_2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [7:0]  id_ctrl;
   logic        flush, stall_ext;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_dst, wb_dst;
   logic [31:0] mem_result, wb_result;
   logic        ex_valid;
   logic [7:0]  ex_ctrl;
   logic [4:0]  ex_rs, ex_rt, ex_dst;
   logic [31:0] ex_imm, ex_opA, ex_opB;
   logic        id_stall;

   int   n_checks = 0;
   int   n_fail   = 0;
   ex_t  m;
   ex_t  sb[$];
   logic last_stall;
   int   stall_cnt;

   id_ex_pipeline_reg dut (
      .clk            (clk),
      .reset          (reset),
      .id_valid       (id_valid),
      .id_Read_Data_1 (id_Read_Data_1),
      .id_Read_Data_2 (id_Read_Data_2),
      .id_rs          (id_rs),
      .id_rt          (id_rt),
      .id_rd          (id_rd),
      .id_imm         (id_imm),
      .id_ctrl        (id_ctrl),
      .flush          (flush),
      .stall_ext      (stall_ext),
      .mem_reg_write  (mem_reg_write),
      .mem_dst        (mem_dst),
      .mem_result     (mem_result),
      .wb_reg_write   (wb_reg_write),
      .wb_dst         (wb_dst),
      .wb_result      (wb_result),
      .ex_valid       (ex_valid),
      .ex_ctrl        (ex_ctrl),
      .ex_rs          (ex_rs),
      .ex_rt          (ex_rt),
      .ex_dst         (ex_dst),
      .ex_imm         (ex_imm),
      .ex_opA         (ex_opA),
      .ex_opB         (ex_opB),
      .id_stall       (id_stall)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic hazard_m();
      logic ex_m, mem_m;
      ex_m  = m.valid && (m.dst != 5'd0) && ((m.dst == id_rs) || (m.dst == id_rt));
      mem_m = mem_reg_write && (mem_dst != 5'd0) && ((mem_dst == id_rs) || (mem_dst == id_rt));
`ifdef FORWARDING_EN
      return ex_m && m.ctrl[1];
`else
      return (ex_m && m.ctrl[0]) || mem_m;
`endif
   endfunction

   function automatic logic [31:0] fwd_exp(input logic [31:0] v, input logic [4:0] r);
`ifdef FORWARDING_EN
      if (mem_reg_write && (mem_dst != 5'd0) && (mem_dst == r)) return mem_result;
      if (wb_reg_write && (wb_dst != 5'd0) && (wb_dst == r)) return wb_result;
`endif
      return v;
   endfunction

   function automatic ex_t model_next();
      ex_t n;
      n = m;
      if (!stall_ext) begin
         if (flush || (id_valid && hazard_m())) begin
            n = '0;
         end else begin
            n.valid = id_valid;
            n.ctrl  = id_ctrl;
            n.rs    = id_rs;
            n.rt    = id_rt;
            n.dst   = id_ctrl[5] ? id_rd : id_rt;
            n.imm   = id_imm;
            n.a     = id_Read_Data_1;
            n.b     = id_Read_Data_2;
         end
      end
      return n;
   endfunction

   task automatic check_ex(input string tag);
      check_val({tag, "_valid"}, {31'd0, ex_valid}, {31'd0, m.valid});
      check_val({tag, "_ctrl"},  {24'd0, ex_ctrl},  {24'd0, m.ctrl});
      check_val({tag, "_rs"},    {27'd0, ex_rs},    {27'd0, m.rs});
      check_val({tag, "_rt"},    {27'd0, ex_rt},    {27'd0, m.rt});
      check_val({tag, "_dst"},   {27'd0, ex_dst},   {27'd0, m.dst});
      check_val({tag, "_imm"},   ex_imm,            m.imm);
      check_val({tag, "_opA"},   ex_opA,            fwd_exp(m.a, m.rs));
      check_val({tag, "_opB"},   ex_opB,            fwd_exp(m.b, m.rt));
   endtask

   // One clock: check the combinational stall, push the expected EX state,
   // then after the edge pop it and compare.
   task automatic cycle(input string tag);
      ex_t e;
      #1;
      last_stall = id_stall;
      check_val({tag, "_id_stall"}, {31'd0, id_stall},
                {31'd0, id_valid && !flush && (hazard_m() || stall_ext)});
      sb.push_back(model_next());
      @(posedge clk);
      #1;
      e = sb.pop_front();
      m = e;
      check_ex(tag);
   endtask

   task automatic set_id(input logic v, input logic [7:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
      id_valid       = v;
      id_ctrl        = c;
      id_rs          = rs;
      id_rt          = rt;
      id_rd          = rd;
      id_imm         = imm;
      id_Read_Data_1 = $urandom;
      id_Read_Data_2 = $urandom;
   endtask

   task automatic clear_side();
      flush = 0; stall_ext = 0;
      mem_reg_write = 0; mem_dst = 0; mem_result = 0;
      wb_reg_write = 0; wb_dst = 0; wb_result = 0;
   endtask

   initial begin
      reset = 0;
      clear_side();
      set_id(1, 8'h21, 5'd1, 5'd2, 5'd3, 32'h10);
      stall_ext = 1;
      m = '0;
      #12;
      check_ex("rst");
      check_val("rst_id_stall", {31'd0, id_stall}, 32'd0);
      stall_ext = 0;
      @(negedge clk);
      reset = 1;

      // 1: captures, then reset dropped mid-cycle
      set_id(1, 8'h21, 5'd1, 5'd2, 5'd3, 32'h11); cycle("cap1");
      set_id(1, 8'h13, 5'd5, 5'd6, 5'd7, 32'h22); cycle("cap2");
      set_id(1, 8'hE1, 5'd8, 5'd9, 5'd10, 32'h33); cycle("cap3");
      stall_ext = 1;
      #3 reset = 0;
      #1;
      m = '0;
      sb.delete();
      check_ex("rst_mid");
      check_val("rst_mid_id_stall", {31'd0, id_stall}, 32'd0);
      @(negedge clk);
      reset = 1;
      stall_ext = 0;

      // 2: load-use, lw r4 in EX then add reading r4
      set_id(0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0); cycle("nop2");
      set_id(1, 8'h13, 5'd1, 5'd4, 5'd0, 32'h4); cycle("lw");
      set_id(1, 8'h21, 5'd4, 5'd5, 5'd6, 32'h0);
      stall_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cycle("lu");
         if (!last_stall) break;
         stall_cnt++;
         if (i == 0) begin mem_reg_write = 1; mem_dst = 5'd4; mem_result = 32'hAAAA; end
         if (i == 1) begin mem_reg_write = 0; wb_reg_write = 1; wb_dst = 5'd4; wb_result = 32'hBBBB; end
      end
`ifdef FORWARDING_EN
      check_val("lu_stall_cycles", stall_cnt, 32'd1);
`else
      check_val("lu_stall_cycles", stall_cnt, 32'd2);
`endif
      check_val("lu_captured_valid", {31'd0, ex_valid}, 32'd1);
      check_val("lu_captured_rs", {27'd0, ex_rs}, 32'd4);
      clear_side();

      // 3: flush, and flush ignored under stall_ext
      set_id(1, 8'h01, 5'd8, 5'd9, 5'd10, 32'h55); cycle("pre3");
      set_id(1, 8'h21, 5'd11, 5'd12, 5'd13, 32'h66);
      flush = 1;
      cycle("flush");
      check_val("flush_ctrl", {24'd0, ex_ctrl}, 32'd0);
      flush = 0;
      set_id(1, 8'h01, 5'd14, 5'd15, 5'd16, 32'h77); cycle("pre3b");
      set_id(1, 8'h21, 5'd17, 5'd18, 5'd19, 32'h88);
      flush = 1; stall_ext = 1;
      cycle("flush_held");
      check_val("flush_held_valid", {31'd0, ex_valid}, 32'd1);
      stall_ext = 0;
      cycle("flush_rel");
      flush = 0;

      // 4: back-pressure for three cycles
      set_id(1, 8'h21, 5'd20, 5'd21, 5'd22, 32'h99); cycle("pre4");
      set_id(1, 8'h21, 5'd23, 5'd24, 5'd25, 32'hABC);
      stall_ext = 1;
      stall_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cycle("bp");
         if (last_stall) stall_cnt++;
      end
      check_val("bp_stall_cycles", stall_cnt, 32'd3);
      check_val("bp_imm_held", ex_imm, 32'h99);
      stall_ext = 0;
      cycle("bp_rel");
      check_val("bp_rel_imm", ex_imm, 32'hABC);

`ifdef FORWARDING_EN
      // 5: forwarding priority
      set_id(1, 8'h01, 5'd2, 5'd9, 5'd0, 32'h0);
      id_Read_Data_1 = 32'h11;
      cycle("pre5");
      set_id(0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0);
      mem_reg_write = 1; mem_dst = 5'd2; mem_result = 32'h55;
      wb_reg_write = 1; wb_dst = 5'd2; wb_result = 32'h66;
      #1 check_val("fwd_mem", ex_opA, 32'h55);
      mem_reg_write = 0;
      #1 check_val("fwd_wb", ex_opA, 32'h66);
      wb_dst = 5'd0;
      #1 check_val("fwd_none", ex_opA, 32'h11);
      clear_side();
`endif

      // 6: ALU RAW, add writing r3 in EX, consumer reads r3
      set_id(0, 8'h00, 5'd0, 5'd0, 5'd0, 32'h0); cycle("nop6");
      set_id(1, 8'h21, 5'd1, 5'd2, 5'd3, 32'h0); cycle("add");
      set_id(1, 8'h21, 5'd7, 5'd3, 5'd8, 32'h0);
      stall_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cycle("raw");
         if (!last_stall) break;
         stall_cnt++;
         if (i == 0) begin mem_reg_write = 1; mem_dst = 5'd3; mem_result = 32'hCCCC; end
         if (i == 1) begin mem_reg_write = 0; wb_reg_write = 1; wb_dst = 5'd3; wb_result = 32'hDDDD; end
      end
`ifdef FORWARDING_EN
      check_val("raw_stall_cycles", stall_cnt, 32'd0);
`else
      check_val("raw_stall_cycles", stall_cnt, 32'd2);
`endif
      check_val("raw_captured_rt", {27'd0, ex_rt}, 32'd3);
      clear_side();

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         set_id(1'($urandom_range(0, 3) != 0), 8'($urandom),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom);
         flush         = ($urandom_range(0, 5) == 0);
         stall_ext     = ($urandom_range(0, 4) == 0);
         mem_reg_write = 1'($urandom);
         mem_dst       = 5'($urandom_range(0, 3));
         mem_result    = $urandom;
         wb_reg_write  = 1'($urandom);
         wb_dst        = 5'($urandom_range(0, 3));
         wb_result     = $urandom;
         cycle("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
